// File: rtl/jpeg_dec_pkg.sv
// Shared constants for the JPEG decode token path: token field layout, special
// run/value encodings, block geometry and the RLE expander state set.
package jpeg_dec_pkg;

   localparam int RUN_MSB = 15;
   localparam int RUN_LSB = 12;
   localparam int VAL_MSB = 11;

   localparam logic [15:0] EOB_TOK = 16'h0000;
   localparam logic [15:0] ZRL_TOK = 16'hF000;

   localparam int BLK_LEN = 64;
   localparam int POS_W   = 7;
   localparam int CNT_W   = 5;

   typedef enum logic [2:0] {DC, AC, ZEROS, VAL, FILL, EOS} rleState_t;

endpackage

// File: rtl/jpeg_dectoken_rle_expand.sv
// Expands run/value decTokens into 64 zig-zag coefficients per block.
// Optional sticky format-error flag is built when JPEG_RLE_ERRCHK_EN is defined.
module jpeg_dectoken_rle_expand #(
   parameter int TOK_W  = 16,
   parameter int VAL_W  = 12,
   parameter int COEF_W = 16
) (
   input  logic              clock,
   input  logic              reset,
   input  logic [TOK_W-1:0]  decToken_d,
   input  logic              decToken_e,
   input  logic              decToken_v,
   output logic              decToken_b,
   output logic [COEF_W-1:0] coef_d,
   output logic              coef_e,
   output logic              coef_v,
   input  logic              coef_b,
   output logic              err
);
   import jpeg_dec_pkg::*;

   rleState_t         stateReg, stateNext;
   logic [POS_W-1:0]  posReg, posNext;
   logic [CNT_W-1:0]  cntReg, cntNext;
   logic [VAL_W-1:0]  valReg, valNext;
   logic              zrlReg, zrlNext;
   logic              eosPendReg, eosPendNext;
   logic [COEF_W-1:0] coefDReg, coefDNext;
   logic              coefEReg, coefENext;
   logic              coefVReg, coefVNext;

   logic              slotFree;
   logic              tokAccept;
   logic              posWrap;
   logic [POS_W-1:0]  posInc;
   logic [3:0]        tokRun;
   logic [VAL_W-1:0]  tokVal;
   logic [COEF_W-1:0] tokSext;
   logic [COEF_W-1:0] valSext;
   logic              isEob;
   logic              isZrl;

   assign slotFree   = !coefVReg | !coef_b;
   assign decToken_b = !(((stateReg == DC) || (stateReg == AC)) && slotFree);
   assign tokAccept  = decToken_v & !decToken_b;
   assign posWrap    = (posReg == POS_W'(BLK_LEN - 1));
   assign posInc     = posWrap ? '0 : posReg + POS_W'(1);
   assign tokRun     = decToken_d[RUN_MSB:RUN_LSB];
   assign tokVal     = decToken_d[VAL_MSB:0];
   assign tokSext    = {{(COEF_W-VAL_W){tokVal[VAL_W-1]}}, tokVal};
   assign valSext    = {{(COEF_W-VAL_W){valReg[VAL_W-1]}}, valReg};
   assign isEob      = (decToken_d == EOB_TOK);
   assign isZrl      = (decToken_d == ZRL_TOK);

   // Every AC token emits its first coefficient on the accepting edge; a wrap
   // of pos always ends the block and returns to DC, dropping any leftovers.
   always_comb begin
      stateNext   = stateReg;
      posNext     = posReg;
      cntNext     = cntReg;
      valNext     = valReg;
      zrlNext     = zrlReg;
      eosPendNext = eosPendReg;
      coefDNext   = coefDReg;
      coefENext   = coefEReg;
      coefVNext   = coefVReg;
      if (slotFree) begin
         coefVNext = 1'b0;
         coefENext = 1'b0;
         case (stateReg)
            DC: begin
               if (tokAccept) begin
                  if (decToken_e) begin
                     stateNext = EOS;
                  end else begin
                     coefVNext = 1'b1;
                     coefDNext = tokSext;
                     posNext   = POS_W'(1);
                     stateNext = AC;
                  end
               end
            end
            AC: begin
               if (tokAccept) begin
                  coefVNext = 1'b1;
                  coefDNext = '0;
                  posNext   = posInc;
                  zrlNext   = 1'b0;
                  valNext   = tokVal;
                  if (decToken_e) begin
                     eosPendNext = !posWrap;
                     stateNext   = posWrap ? EOS : FILL;
                  end else if (isEob) begin
                     stateNext = posWrap ? DC : FILL;
                  end else if (tokRun == 4'd0) begin
                     coefDNext = tokSext;
                     stateNext = posWrap ? DC : AC;
                  end else begin
                     cntNext   = isZrl ? CNT_W'(15) : CNT_W'(tokRun) - CNT_W'(1);
                     zrlNext   = isZrl;
                     if (posWrap)
                        stateNext = DC;
                     else if (!isZrl && (tokRun == 4'd1))
                        stateNext = VAL;
                     else
                        stateNext = ZEROS;
                  end
               end
            end
            ZEROS: begin
               coefVNext = 1'b1;
               coefDNext = '0;
               posNext   = posInc;
               cntNext   = cntReg - CNT_W'(1);
               if (posWrap)
                  stateNext = DC;
               else if (cntReg == CNT_W'(1))
                  stateNext = zrlReg ? AC : VAL;
            end
            VAL: begin
               coefVNext = 1'b1;
               coefDNext = valSext;
               posNext   = posInc;
               stateNext = posWrap ? DC : AC;
            end
            FILL: begin
               coefVNext = 1'b1;
               coefDNext = '0;
               posNext   = posInc;
               if (posWrap) begin
                  stateNext   = eosPendReg ? EOS : DC;
                  eosPendNext = 1'b0;
               end
            end
            EOS: begin
               coefVNext   = 1'b1;
               coefENext   = 1'b1;
               coefDNext   = '0;
               eosPendNext = 1'b0;
               stateNext   = DC;
            end
            default: stateNext = DC;
         endcase
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         stateReg   <= DC;
         posReg     <= '0;
         cntReg     <= '0;
         valReg     <= '0;
         zrlReg     <= 1'b0;
         eosPendReg <= 1'b0;
         coefDReg   <= '0;
         coefEReg   <= 1'b0;
         coefVReg   <= 1'b0;
      end else begin
         stateReg   <= stateNext;
         posReg     <= posNext;
         cntReg     <= cntNext;
         valReg     <= valNext;
         zrlReg     <= zrlNext;
         eosPendReg <= eosPendNext;
         coefDReg   <= coefDNext;
         coefEReg   <= coefENext;
         coefVReg   <= coefVNext;
      end
   end

   assign coef_d = coefDReg;
   assign coef_e = coefEReg;
   assign coef_v = coefVReg;

`ifdef JPEG_RLE_ERRCHK_EN
   logic errReg;
   logic zrlLastReg;
   logic dropEvt;

   // A drop is any run or value still owed when the block's last slot is emitted.
   always_comb begin
      dropEvt = 1'b0;
      if (slotFree && posWrap) begin
         case (stateReg)
            AC:      dropEvt = tokAccept & !decToken_e & (tokRun != 4'd0);
            ZEROS:   dropEvt = (cntReg != CNT_W'(1)) | !zrlReg;
            default: dropEvt = 1'b0;
         endcase
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         errReg     <= 1'b0;
         zrlLastReg <= 1'b0;
      end else begin
         if (dropEvt)
            errReg <= 1'b1;
         if (tokAccept) begin
            if ((stateReg == AC) && !decToken_e && isEob && zrlLastReg)
               errReg <= 1'b1;
            zrlLastReg <= (stateReg == AC) & !decToken_e & isZrl;
         end
      end
   end

   assign err = errReg;
`else
   assign err = 1'b0;
`endif

endmodule

// File: tb/tb_jpeg_dectoken_rle_expand.sv
// Directed bench for the RLE expander: a queue-based block model predicts the
// coefficient stream, checked on every transfer, plus literal spot checks.
module tb_jpeg_dectoken_rle_expand;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic [15:0] decToken_d = '0;
   logic        decToken_e = 1'b0;
   logic        decToken_v = 1'b0;
   logic        decToken_b;
   logic [15:0] coef_d;
   logic        coef_e;
   logic        coef_v;
   logic        coef_b = 1'b0;
   logic        err;

   always #5 clock = ~clock;

   jpeg_dectoken_rle_expand dut (
      .clock      (clock),
      .reset      (reset),
      .decToken_d (decToken_d),
      .decToken_e (decToken_e),
      .decToken_v (decToken_v),
      .decToken_b (decToken_b),
      .coef_d     (coef_d),
      .coef_e     (coef_e),
      .coef_v     (coef_v),
      .coef_b     (coef_b),
      .err        (err)
   );

   int checkCnt = 0;
   int passCnt  = 0;

   logic [16:0] expQ[$];
   int          mPos = 0;
   bit          inBlock = 0;
   bit          lastZrl = 0;
   bit          modelErr = 0;

   logic [15:0] capData[0:255];
   int          capN = 0;
   int          eosN = 0;

   bit          randB = 0;
   bit          holdB = 0;
   bit          prevStall = 0;
   logic [16:0] prevOut = '0;
   bit          expectLat = 0;

   task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
      checkCnt++;
      if (got === exp) passCnt++;
      else $display("FAIL %s got=%0h expected=%0h at %0t", nm, got, exp, $time);
   endtask

   task automatic pushData(input logic [15:0] d);
      expQ.push_back({1'b0, d});
      mPos++;
   endtask

   // Block-level model: place each token's zeros/value into the 64-slot block.
   task automatic modelTok(input logic [15:0] t, input logic e);
      int          z;
      logic [15:0] v;
      bit          zrlHere;
      v       = {{4{t[11]}}, t[11:0]};
      zrlHere = inBlock && !e && (t == 16'hF000);
      if (!inBlock) begin
         if (e) expQ.push_back({1'b1, 16'h0000});
         else begin
            mPos = 0;
            pushData(v);
            inBlock = 1;
         end
      end else if (e) begin
         while (mPos < 64) pushData(16'h0000);
         expQ.push_back({1'b1, 16'h0000});
         inBlock = 0;
      end else if (t == 16'h0000) begin
         if (lastZrl) modelErr = 1;
         while (mPos < 64) pushData(16'h0000);
         inBlock = 0;
      end else begin
         z = (t == 16'hF000) ? 16 : int'(t[15:12]);
         while (z > 0 && mPos < 64) begin
            pushData(16'h0000);
            z--;
         end
         if (t != 16'hF000) begin
            if (mPos < 64) pushData(v);
            else modelErr = 1;
         end else if (z > 0) modelErr = 1;
         if (mPos == 64) inBlock = 0;
      end
      lastZrl = zrlHere;
   endtask

   always @(negedge clock) begin
      if (reset) begin
         expQ.delete();
         inBlock   = 0;
         mPos      = 0;
         lastZrl   = 0;
         modelErr  = 0;
         prevStall = 0;
         expectLat = 0;
      end else begin
         if (prevStall) begin
            check("stall_hold_v", 32'(coef_v), 32'd1);
            check("stall_hold_d", 32'({coef_e, coef_d}), 32'(prevOut));
         end
         if (expectLat) check("latency_v", 32'(coef_v), 32'd1);
         expectLat = 0;
         if (coef_v && !coef_b) begin
            if (expQ.size() == 0) begin
               checkCnt++;
               $display("FAIL unexpected_coef got=%0h expected=none at %0t", {coef_e, coef_d}, $time);
            end else begin
               check("coef", 32'({coef_e, coef_d}), 32'(expQ.pop_front()));
               if (coef_e) eosN++;
               else if (capN < 256) begin
                  capData[capN] = coef_d;
                  capN++;
               end
            end
         end
         prevStall = coef_v && coef_b;
         prevOut   = {coef_e, coef_d};
         if (decToken_v && !decToken_b) begin
            check("accept_only_when_drained", 32'(expQ.size()), 32'd0);
            modelTok(decToken_d, decToken_e);
            if (!decToken_e) expectLat = 1;
         end
      end
   end

   initial begin
      forever begin
         @(posedge clock);
         #1;
         coef_b = randB ? 1'($urandom_range(0, 1)) : holdB;
      end
   end

   task automatic sendTok(input logic [15:0] d, input logic e);
      int n;
      bit done;
      n = 0;
      done = 0;
      decToken_d = d;
      decToken_e = e;
      decToken_v = 1'b1;
      while (!done && n < 3000) begin
         @(negedge clock);
         if (!decToken_b) done = 1;
         n++;
      end
      if (!done) begin
         checkCnt++;
         $display("FAIL send_timeout got=stalled expected=accept tok=%0h", d);
      end
      @(posedge clock);
      #1;
      decToken_v = 1'b0;
      decToken_e = 1'b0;
   endtask

   task automatic waitIdle();
      int n;
      n = 0;
      while (expQ.size() != 0 && n < 3000) begin
         @(negedge clock);
         n++;
      end
      if (expQ.size() != 0) begin
         checkCnt++;
         $display("FAIL drain_timeout got=%0d left expected=0", expQ.size());
      end
      repeat (3) @(negedge clock);
      check("idle_v", 32'(coef_v), 32'd0);
      @(posedge clock);
      #1;
   endtask

   task automatic clearCap();
      capN = 0;
      eosN = 0;
   endtask

   function automatic bit errExp(input bit m);
`ifdef JPEG_RLE_ERRCHK_EN
      return m;
`else
      return 1'b0 & m;
`endif
   endfunction

   function automatic bit errLit();
`ifdef JPEG_RLE_ERRCHK_EN
      return 1'b1;
`else
      return 1'b0;
`endif
   endfunction

   initial begin
      reset = 1'b1;
      repeat (3) @(posedge clock);
      #1;
      check("rst_coef_v", 32'(coef_v), 32'd0);
      check("rst_coef_d", 32'(coef_d), 32'd0);
      check("rst_coef_e", 32'(coef_e), 32'd0);
      check("rst_err", 32'(err), 32'd0);
      check("rst_decToken_b", 32'(decToken_b), 32'd0);
      reset = 1'b0;

      // 1: DC then EOB
      clearCap();
      sendTok(16'h0005, 1'b0);
      sendTok(16'h0000, 1'b0);
      waitIdle();
      check("t1_count", 32'(capN), 32'd64);
      check("t1_idx0", 32'(capData[0]), 32'h5);
      check("t1_idx63", 32'(capData[63]), 32'h0);
      check("t1_eos", 32'(eosN), 32'd0);

      // EOS while in DC: only the end marker
      clearCap();
      sendTok(16'h1234, 1'b1);
      waitIdle();
      check("dc_eos_count", 32'(eosN), 32'd1);
      check("dc_eos_data", 32'(capN), 32'd0);

      // 2: negative DC, run-2 value
      clearCap();
      sendTok(16'h0FFF, 1'b0);
      sendTok(16'h2003, 1'b0);
      sendTok(16'h0000, 1'b0);
      waitIdle();
      check("t2_idx0", 32'(capData[0]), 32'hFFFF);
      check("t2_idx2", 32'(capData[2]), 32'h0);
      check("t2_idx3", 32'(capData[3]), 32'h3);
      check("t2_count", 32'(capN), 32'd64);

      // 3: three ZRLs then a value
      clearCap();
      sendTok(16'h0001, 1'b0);
      repeat (3) sendTok(16'hF000, 1'b0);
      sendTok(16'h0007, 1'b0);
      sendTok(16'h0000, 1'b0);
      waitIdle();
      check("t3_idx48", 32'(capData[48]), 32'h0);
      check("t3_idx49", 32'(capData[49]), 32'h7);
      check("t3_count", 32'(capN), 32'd64);
      check("t3_err", 32'(err), 32'(errExp(modelErr)));

      // 4: overflow drops the value; next token starts a new block
      clearCap();
      sendTok(16'h0001, 1'b0);
      repeat (3) sendTok(16'hF000, 1'b0);
      sendTok(16'hF00A, 1'b0);
      sendTok(16'h0009, 1'b0);
      sendTok(16'h0000, 1'b0);
      waitIdle();
      check("t4_idx63", 32'(capData[63]), 32'h0);
      check("t4_next_dc", 32'(capData[64]), 32'h9);
      check("t4_count", 32'(capN), 32'd128);
      check("t4_err_model", 32'(err), 32'(errExp(modelErr)));
      check("t4_err_lit", 32'(err), 32'(errLit()));

      // 5: test 2 under random back-pressure
      randB = 1;
      clearCap();
      sendTok(16'h0FFF, 1'b0);
      sendTok(16'h2003, 1'b0);
      sendTok(16'h0000, 1'b0);
      randB = 0;
      waitIdle();
      check("t5_idx0", 32'(capData[0]), 32'hFFFF);
      check("t5_idx3", 32'(capData[3]), 32'h3);
      check("t5_count", 32'(capN), 32'd64);

      // 6: EOS mid-block pads to 64 then ends
      clearCap();
      sendTok(16'h0002, 1'b0);
      sendTok(16'h0001, 1'b0);
      sendTok(16'h0000, 1'b1);
      waitIdle();
      check("t6_count", 32'(capN), 32'd64);
      check("t6_idx1", 32'(capData[1]), 32'h1);
      check("t6_idx2", 32'(capData[2]), 32'h0);
      check("t6_eos", 32'(eosN), 32'd1);

      // reset while emitting ZRL zeros
      sendTok(16'h0002, 1'b0);
      sendTok(16'hF000, 1'b0);
      repeat (3) @(posedge clock);
      #1;
      reset = 1'b1;
      @(posedge clock);
      #1;
      check("mid_rst_coef_v", 32'(coef_v), 32'd0);
      check("mid_rst_coef_d", 32'(coef_d), 32'd0);
      check("mid_rst_decToken_b", 32'(decToken_b), 32'd0);
      check("mid_rst_err", 32'(err), 32'd0);
      reset = 1'b0;
      clearCap();
      sendTok(16'h0004, 1'b0);
      sendTok(16'h0000, 1'b0);
      waitIdle();
      check("post_rst_idx0", 32'(capData[0]), 32'h4);
      check("post_rst_count", 32'(capN), 32'd64);

      // ZRL directly followed by EOB
      clearCap();
      sendTok(16'h0001, 1'b0);
      sendTok(16'hF000, 1'b0);
      sendTok(16'h0000, 1'b0);
      waitIdle();
      check("zrl_eob_count", 32'(capN), 32'd64);
      check("zrl_eob_err", 32'(err), 32'(errLit()));
      check("zrl_eob_err_model", 32'(err), 32'(errExp(modelErr)));

      $display("%0d/%0d checks passed", passCnt, checkCnt);
      $finish;
   end

endmodule
